instruction_fetch: RTL and testbench

- Producer end of the 32-bit instruction-word interface that the instruction register samples each `clk`.
- Holds the PC and requests words from instruction memory over a req/ack handshake, one request outstanding at most.
- Presents words with `valid` and the matching `pc_out`.
- Uses a 1-entry skid buffer to absorb pipeline stalls, and squashes in-flight fetches on jump/branch redirect.

---
 rtl/instruction_fetch.sv | 162 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Producer side of the 32-bit instruction-word interface. Keeps the fetch PC,
// fetches words from instruction memory over a req/ack handshake with at most
// one request outstanding, and presents each word with valid/pc_out to the
// instruction register. A one-entry skid buffer catches the word that lands
// while the output is stalled. A redirect flushes the output and skid and
// restarts fetching at the target. An unacknowledged request is drained first
// because the memory cannot abandon it.
//
// Parameters
//   RESET_PC     PC loaded on reset (the low two bits are ignored)
//   NOP_WORD     word driven on value whenever valid is low
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   imem_req     fetch request, held with a stable imem_addr until imem_ack
//   imem_addr    word-aligned byte address of the request
//   imem_rdata   instruction word, meaningful only while imem_ack is high
//   imem_ack     memory completes the request this cycle
//   stall        downstream is not consuming; the output word must hold
//   redirect     jump/branch taken; flush and refetch from redirect_pc
//   redirect_pc  redirect target (the low two bits are ignored)
//   value        instruction word to the instruction register
//   valid        value holds a real instruction
//   pc_out       byte address of the word on value
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] value,
  output logic        valid,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {RST, FETCH, WAIT, DRAIN} state_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Modulo 2^32: FFFF_FFFC wraps to 0000_0000.
  function automatic logic [31:0] next_pc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  localparam logic [31:0] RESET_PC_AL = word_align(RESET_PC);

  state_t      state_q, state_d;

  // Fetch stage
  logic [31:0] pc_p0;
  logic [31:0] drain_addr_p0;

  // Output stage and its skid entry
  logic [31:0] value_p1;
  logic        vld_p1;
  logic [31:0] pc_out_p1;
  logic [31:0] skid_word_p1;
  logic [31:0] skid_pc_p1;
  logic        skid_full_p1;

  logic consume;
  logic out_free;
  logic fetch_ack;
  logic to_out;
  logic to_skid;
  logic skid_pop;
  logic start_drain;

  assign consume     = vld_p1 && !stall;
  assign out_free    = !vld_p1 || consume;
  assign fetch_ack   = (state_q == FETCH) && imem_ack;
  assign to_out      = fetch_ack && out_free && !redirect;
  assign to_skid     = fetch_ack && !out_free && !redirect;
  assign skid_pop    = (state_q == WAIT) && consume && !redirect;
  // The request in flight cannot be withdrawn, so it is remembered and drained.
  assign start_drain = redirect && (state_q == FETCH) && !imem_ack;

  // Request is a function of registered state only, never of stall.
  assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr = (state_q == DRAIN) ? drain_addr_p0 : pc_p0;

  assign value  = value_p1;
  assign valid  = vld_p1;
  assign pc_out = pc_out_p1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST:   state_d = FETCH;
      FETCH: begin
        if (redirect)     state_d = imem_ack ? FETCH : DRAIN;
        else if (to_skid) state_d = WAIT;
      end
      WAIT:  if (redirect || consume) state_d = FETCH;
      // A redirect during a drain only moves pc; the drain still completes.
      DRAIN: if (imem_ack) state_d = FETCH;
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST;
      pc_p0        <= RESET_PC_AL;
      vld_p1       <= 1'b0;
      value_p1     <= NOP_WORD;
      pc_out_p1    <= 32'h0000_0000;
      skid_full_p1 <= 1'b0;
    end else begin
      state_q <= state_d;

      if (redirect)       pc_p0 <= word_align(redirect_pc);
      else if (fetch_ack) pc_p0 <= next_pc(pc_p0);

      if (redirect) begin
        vld_p1   <= 1'b0;
        value_p1 <= NOP_WORD;
      end else if (to_out) begin
        vld_p1    <= 1'b1;
        value_p1  <= imem_rdata;
        pc_out_p1 <= pc_p0;
      end else if (skid_pop) begin
        vld_p1    <= 1'b1;
        value_p1  <= skid_word_p1;
        pc_out_p1 <= skid_pc_p1;
      end else if (consume) begin
        vld_p1   <= 1'b0;
        value_p1 <= NOP_WORD;
      end

      if (redirect)      skid_full_p1 <= 1'b0;
      else if (to_skid)  skid_full_p1 <= 1'b1;
      else if (skid_pop) skid_full_p1 <= 1'b0;
    end
  end

  // Payload registers qualified by skid_full_p1 / state; no reset needed.
  always_ff @(posedge clk) begin
    if (to_skid) begin
      skid_word_p1 <= imem_rdata;
      skid_pc_p1   <= pc_p0;
    end
    if (start_drain) drain_addr_p0 <= pc_p0;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps

module tb_instruction_fetch;

  localparam logic [31:0] MAGIC = 32'hA5A5_0000;
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] value, pc_out;
  logic        valid;

  logic        req2, ack2, valid2;
  logic [31:0] addr2, rdata2, value2, pc_out2;

  // Memory model: answers after 'lat' waiting cycles when ack_en allows.
  int   lat;
  int   cnt;
  logic ack_en;

  int checks;
  int errors;

  // Reference model: the stream of consumed words is PC-contiguous from the
  // last reset/redirect target, each word being address ^ MAGIC.
  logic [31:0] exp_pc;
  int          consumed;
  logic        s_cons, s_redir, s_rst;
  logic [31:0] s_pc, s_val, s_tgt;
  logic        prev_req, prev_ack, prev_redir;
  logic [31:0] prev_addr;

  always #5 clk = ~clk;

  assign imem_ack   = imem_req && ack_en && (cnt >= lat);
  assign imem_rdata = imem_ack ? (imem_addr ^ MAGIC) : 32'hDEAD_BEEF;

  assign ack2   = req2;
  assign rdata2 = addr2 ^ MAGIC;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .value(value), .valid(valid), .pc_out(pc_out)
  );

  instruction_fetch #(.RESET_PC(RPC2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req2), .imem_addr(addr2),
    .imem_rdata(rdata2), .imem_ack(ack2),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0000_0000),
    .value(value2), .valid(valid2), .pc_out(pc_out2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  // One clock: sample at the falling edge, return 1ns after the rising edge.
  task automatic step();
    @(negedge clk);
    if (rst_n) begin
      if (!valid) chk("nop_when_invalid", value, NOP);
      chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
      if (prev_req && !prev_ack) begin
        chk1("req_held", imem_req, 1'b1);
        chk("addr_held", imem_addr, prev_addr);
      end
      if (prev_redir) chk1("flush_valid", valid, 1'b0);
    end
    s_cons     = rst_n && valid && !stall;
    s_pc       = pc_out;
    s_val      = value;
    s_redir    = rst_n && redirect;
    s_tgt      = redirect_pc;
    s_rst      = !rst_n;
    prev_req   = rst_n && imem_req;
    prev_ack   = imem_ack;
    prev_addr  = imem_addr;
    prev_redir = s_redir;
    @(posedge clk);
    #1;
    if (s_cons) begin
      chk("stream_pc", s_pc, exp_pc);
      chk("stream_word", s_val, exp_pc ^ MAGIC);
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (s_redir) exp_pc = s_tgt & 32'hFFFF_FFFC;
    if (s_rst)   exp_pc = 32'h0000_0000;
    cnt = (prev_req && !prev_ack) ? cnt + 1 : 0;
  endtask

  initial begin
    logic [31:0] p;
    int          n;
    checks = 0; errors = 0; consumed = 0;
    exp_pc = 32'h0; cnt = 0; lat = 0; ack_en = 1'b1;
    prev_req = 1'b0; prev_ack = 1'b0; prev_redir = 1'b0; prev_addr = 32'h0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) step();
    chk1("rst_valid", valid, 1'b0);
    chk("rst_value", value, NOP);
    chk("rst_pc_out", pc_out, 32'h0);
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk1("rst_req2", req2, 1'b0);
    chk("rst_addr2", addr2, RPC2);

    // Zero-wait streaming from reset; dut2 wraps past FFFF_FFFC
    rst_n = 1'b1;
    step();
    chk1("e1_req", imem_req, 1'b1);
    chk("e1_addr", imem_addr, 32'h0);
    chk1("e1_valid", valid, 1'b0);
    chk("e1_addr2", addr2, 32'hFFFF_FFF8);
    step();
    chk1("e2_valid", valid, 1'b1);
    chk("e2_pc_out", pc_out, 32'h0);
    chk("e2_value", value, MAGIC);
    chk("e2_addr", imem_addr, 32'h4);
    chk("e2_addr2", addr2, 32'hFFFF_FFFC);
    chk("e2_pc_out2", pc_out2, 32'hFFFF_FFF8);
    step();
    chk("e3_addr2", addr2, 32'h0000_0000);
    chk("e3_pc_out2", pc_out2, 32'hFFFF_FFFC);
    chk("e3_pc_out", pc_out, 32'h4);
    step();
    chk("e4_addr2", addr2, 32'h0000_0004);
    chk("e4_pc_out2", pc_out2, 32'h0000_0000);
    chk("e4_value2", value2, MAGIC);
    for (int k = 5; k <= 10; k++) begin
      step();
      chk1("run_valid", valid, 1'b1);
      chk("run_pc_out", pc_out, 32'(4 * (k - 2)));
      chk("run_addr", imem_addr, 32'(4 * (k - 1)));
    end

    // Stall for three cycles while an ack lands: word goes to the skid
    p = exp_pc;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk1("stall_valid", valid, 1'b1);
      chk("stall_pc_out", pc_out, p);
      chk("stall_value", value, p ^ MAGIC);
      chk1("wait_req", imem_req, 1'b0);
    end
    stall = 1'b0;
    step();
    chk("skid_pc_out", pc_out, p + 32'd4);
    chk("skid_value", value, (p + 32'd4) ^ MAGIC);
    chk1("skid_req", imem_req, 1'b1);
    chk("skid_addr", imem_addr, p + 32'd8);
    step();
    chk("after_skid_pc_out", pc_out, p + 32'd8);

    // Slow memory, redirect before the ack: drain old address, then 0x100
    rst_n = 1'b0;
    step(); step();
    lat = 3;
    rst_n = 1'b1;
    step();
    chk1("slow_req", imem_req, 1'b1);
    chk("slow_addr", imem_addr, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    chk("drain_addr0", imem_addr, 32'h0);
    chk1("drain_req", imem_req, 1'b1);
    chk1("drain_valid", valid, 1'b0);
    step();
    chk("drain_addr1", imem_addr, 32'h0);
    step();
    chk("drain_addr2", imem_addr, 32'h0);
    step();
    chk("post_drain_addr", imem_addr, 32'h100);
    chk1("post_drain_valid", valid, 1'b0);
    n = 0;
    while (!valid && n < 20) begin step(); n++; end
    chk1("redir_first_valid", valid, 1'b1);
    chk("redir_first_pc", pc_out, 32'h100);
    chk("redir_first_word", value, 32'h100 ^ MAGIC);

    // Redirect coinciding with ack while stalled
    lat = 0;
    repeat (3) step();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    chk1("coincide_ack", imem_ack, 1'b1);
    step();
    redirect = 1'b0;
    chk1("coincide_valid", valid, 1'b0);
    chk("coincide_value", value, NOP);
    chk("coincide_addr", imem_addr, 32'h200);
    step();
    chk1("coincide_next_valid", valid, 1'b1);
    chk("coincide_next_pc", pc_out, 32'h200);

    // Redirect while in WAIT with the skid full
    step();
    chk1("wait2_req", imem_req, 1'b0);
    chk("wait2_pc_out", pc_out, 32'h200);
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    redirect = 1'b0;
    chk1("wflush_valid", valid, 1'b0);
    chk1("wflush_req", imem_req, 1'b1);
    chk("wflush_addr", imem_addr, 32'h300);
    stall = 1'b0;
    step();
    chk("wflush_pc0", pc_out, 32'h300);
    step();
    chk("wflush_pc1", pc_out, 32'h304);

    // Asynchronous reset in the middle of a drain
    lat = 3;
    redirect = 1'b1; redirect_pc = 32'h0000_0400;
    step();
    redirect = 1'b0;
    chk("mid_drain_addr", imem_addr, 32'h308);
    chk1("mid_drain_req", imem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("async_req", imem_req, 1'b0);
    chk("async_addr", imem_addr, 32'h0);
    chk1("async_valid", valid, 1'b0);
    chk("async_value", value, NOP);
    chk("async_pc_out", pc_out, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk1("rerun_req", imem_req, 1'b1);
    chk("rerun_addr", imem_addr, 32'h0);

    // Randomised traffic against the stream model
    for (int i = 0; i < 1500; i++) begin
      stall       = ($urandom_range(0, 99) < 30);
      redirect    = ($urandom_range(0, 99) < 5);
      redirect_pc = $urandom;
      ack_en      = ($urandom_range(0, 99) < 70);
      if (i % 100 == 0) lat = $urandom_range(0, 2);
      step();
    end
    redirect = 1'b0; stall = 1'b0; ack_en = 1'b1;
    repeat (20) step();
    chk1("consumed_any", consumed > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
